sc_mult_seq: RTL and testbench
==============================

SC_MULT_SEQ -- requirements
Module: sc_mult_seq

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 32, operand width W; legal range 4..32.
REQ-002 SHALL have port SC_MultSEQ_CLOCK_50  in  1  datapath clock; all state changes on its falling edge.
REQ-003 SHALL have port SC_RegGENERAL_Reset_InHigh  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port SC_MultSEQ_Start_InHigh  in  1  start request, sampled only in IDLE.
REQ-005 SHALL have port SC_MultSEQ_OperandA_In  in  W  multiplicand, driven from a general register output.
REQ-006 SHALL have port SC_MultSEQ_OperandB_In  in  W  multiplier, driven from a general register output.
REQ-007 SHALL have port SC_MultSEQ_ResultLow_Out  out  W  product bits [W-1:0], intended as DataBUS_In of a general register.
REQ-008 SHALL have port SC_MultSEQ_ResultHigh_Out  out  W  product bits [2W-1:W].
REQ-009 SHALL have port SC_MultSEQ_Busy_OutHigh  out  1  high while in RUN or DONE.
REQ-010 SHALL have port SC_MultSEQ_Done_OutHigh  out  1  one-cycle completion pulse, usable directly as a general register Write_InHigh.

Function
REQ-011 SHALL compute the unsigned 2W-bit product A*B by shift-and-add, one multiplier bit per clock.
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 IDLE with Start=1 at a falling edge: latch A and B, clear the accumulator and the iteration counter, go to RUN.
REQ-014 IDLE with Start=0: remain in IDLE; outputs hold their values.
REQ-015 RUN, each edge: if the current multiplier LSB is 1, add the multiplicand to the upper accumulator half with a W+1-bit sum (carry kept); then shift {carry, acc, multiplier} right by 1 and increment the counter.
REQ-016 RUN: on the edge performing iteration W (counter = W-1), load ResultHigh/ResultLow output registers with the final product and go to DONE.
REQ-017 DONE: Done_OutHigh=1 for exactly one cycle; unconditional transition to IDLE on the next edge.
REQ-018 Latency: Done SHALL be high in the cycle after the W-th edge following the start-sampling edge (W+1 edges from start to IDLE).
REQ-019 Result outputs SHALL change only when entering DONE and SHALL hold until the next completion.
REQ-020 Start SHALL be ignored in RUN and DONE (no restart, no queueing); Start held high through DONE starts a new operation in the following IDLE cycle.
REQ-021 Operand input changes after the latch edge SHALL NOT affect the running operation.
REQ-022 Operand value 0 SHALL still take the full W iterations (no early termination).

Reset
REQ-023 Reset high SHALL force IDLE, counter 0, accumulator 0, ResultLow=0, ResultHigh=0, Busy=0, Done=0, immediately and independent of the clock.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation with no Done pulse and no result update.
REQ-025 The first edge after reset release SHALL be handled as a normal IDLE edge.

Structure
REQ-026 A shared package SHALL hold the state encoding constants (IDLE, RUN, DONE) and the default DATAWIDTH_BUS.
REQ-027 The counter width SHALL be derived from W (clog2(W)), not hard-coded.
REQ-028 One sub-module, sc_mult_addshift (combinational W+1-bit conditional add plus right shift), is natural; FSM, counter and registers stay in sc_mult_seq.

Verification
REQ-029 W=32, A=3, B=5, single Start pulse: Done high one cycle, 32 edges after the start edge; ResultLow=0x0000000F, ResultHigh=0x00000000; Busy low afterwards.
REQ-030 A=B=0xFFFFFFFF: ResultHigh=0xFFFFFFFE, ResultLow=0x00000001 (carry path check).
REQ-031 A=0x12345678, B=0: 32-cycle latency preserved; result 0/0; then A=0, B=7: result 0/0.
REQ-032 Start during RUN with new operands, and operands changed mid-RUN: first result unaffected; exactly one Done pulse.
REQ-033 Reset pulsed at iteration 10 of A=6, B=7: outputs 0 immediately, no Done; a restart after release yields ResultLow=42.
REQ-034 Start held high continuously, A=2, B=3: back-to-back operations every W+2 cycles, each giving ResultLow=6, one Done per operation.

Source files
------------

// File: rtl/sc_mult_seq_pkg.sv
// Shared constants for the sequential shift-and-add multiplier: the default
// operand width and the FSM state encoding.
package sc_mult_seq_pkg;

    localparam int SC_MULT_DATAWIDTH_DEF = 32;

    // state | meaning
    // IDLE  | waiting for Start; outputs hold the last product
    // RUN   | one multiplier bit consumed per falling edge
    // DONE  | product valid, Done pulse for one cycle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sc_mult_addshift.sv
// One shift-and-add step: conditionally add the multiplicand to the upper
// accumulator half with carry kept, then shift {carry, acc, multiplier} right.
module sc_mult_addshift #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] mplier_i,
    input  logic [W-1:0] mcand_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] mplier_o
);

    logic [W:0] sum;

    // W+1-bit sum so the carry survives into the shifted accumulator
    always_comb begin
        sum      = {1'b0, acc_i} + (mplier_i[0] ? {1'b0, mcand_i} : {(W+1){1'b0}});
        acc_o    = sum[W:1];
        mplier_o = {sum[0], mplier_i[W-1:1]};
    end

endmodule

// File: rtl/sc_mult_seq.sv
// Sequential unsigned multiplier: W iterations of shift-and-add, result
// registers updated only on completion, single-cycle Done pulse.
module sc_mult_seq
    import sc_mult_seq_pkg::*;
#(
    parameter int DATAWIDTH_BUS = SC_MULT_DATAWIDTH_DEF
) (
    input  logic                     SC_MultSEQ_CLOCK_50,
    input  logic                     SC_RegGENERAL_Reset_InHigh,
    input  logic                     SC_MultSEQ_Start_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SC_MultSEQ_OperandA_In,
    input  logic [DATAWIDTH_BUS-1:0] SC_MultSEQ_OperandB_In,
    output logic [DATAWIDTH_BUS-1:0] SC_MultSEQ_ResultLow_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MultSEQ_ResultHigh_Out,
    output logic                     SC_MultSEQ_Busy_OutHigh,
    output logic                     SC_MultSEQ_Done_OutHigh
);

    localparam int W  = DATAWIDTH_BUS;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  res_lo_q, res_lo_d;
    logic [W-1:0]  res_hi_q, res_hi_d;
    logic [W-1:0]  acc_nxt, mplier_nxt;

    sc_mult_addshift #(.W(W)) u_addshift (
        .acc_i    (acc_q),
        .mplier_i (mplier_q),
        .mcand_i  (mcand_q),
        .acc_o    (acc_nxt),
        .mplier_o (mplier_nxt)
    );

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (SC_MultSEQ_Start_InHigh) begin
                    mcand_d  = SC_MultSEQ_OperandA_In;
                    mplier_d = SC_MultSEQ_OperandB_In;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d    = acc_nxt;
                mplier_d = mplier_nxt;
                cnt_d    = cnt_q + 1'b1;
                // Last iteration: the shifted pair already is the full product
                if (cnt_q == CNT_LAST) begin
                    res_hi_d = acc_nxt;
                    res_lo_d = mplier_nxt;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers, falling-edge clocked with asynchronous reset
    always_ff @(negedge SC_MultSEQ_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
        if (SC_RegGENERAL_Reset_InHigh) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    // Status decode straight from the state register
    always_comb begin
        SC_MultSEQ_Busy_OutHigh   = (state_q == ST_RUN) || (state_q == ST_DONE);
        SC_MultSEQ_Done_OutHigh   = (state_q == ST_DONE);
        SC_MultSEQ_ResultLow_Out  = res_lo_q;
        SC_MultSEQ_ResultHigh_Out = res_hi_q;
    end

endmodule

// File: tb/tb_sc_mult_seq.sv
// Bench for sc_mult_seq: directed scenarios plus random operands, checked
// against a plain arithmetic product and cycle-count expectations.
module tb_sc_mult_seq;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  res_lo;
    logic [W-1:0]  res_hi;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    sc_mult_seq #(.DATAWIDTH_BUS(W)) dut (
        .SC_MultSEQ_CLOCK_50        (clk),
        .SC_RegGENERAL_Reset_InHigh (rst),
        .SC_MultSEQ_Start_InHigh    (start),
        .SC_MultSEQ_OperandA_In     (op_a),
        .SC_MultSEQ_OperandB_In     (op_b),
        .SC_MultSEQ_ResultLow_Out   (res_lo),
        .SC_MultSEQ_ResultHigh_Out  (res_hi),
        .SC_MultSEQ_Busy_OutHigh    (busy),
        .SC_MultSEQ_Done_OutHigh    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation with scrambled operand inputs after the latch edge
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [63:0]  exp;
        logic [W-1:0] plo, phi;
        int n;
        bit seen;
        exp = {32'd0, a} * {32'd0, b};
        plo = res_lo;
        phi = res_hi;
        op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        op_a = $urandom; op_b = $urandom;
        n = 0; seen = 0;
        while (n < 100 && !seen) begin
            tick();
            n++;
            if (done) seen = 1;
            else if (n % 8 == 0) chk({tag, " hold_during_run"}, {phi, plo}, {res_hi, res_lo});
        end
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(W));
        chk({tag, " product"}, {res_hi, res_lo}, exp);
        tick();
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, " busy_low_after"}, 64'(busy), 64'd0);
        chk({tag, " product_hold"}, {res_hi, res_lo}, exp);
    endtask

    initial begin
        int n;
        int ndone;
        bit seen;
        int tdone[$];

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        #3;
        chk("reset_lo", 64'(res_lo), 64'd0);
        chk("reset_hi", 64'(res_hi), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_no_start", 64'(busy), 64'd0);

        run_op(32'd3, 32'd5, "a3b5");
        chk("a3b5_lo", 64'(res_lo), 64'h0F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "carry");
        chk("carry_hi", 64'(res_hi), 64'hFFFF_FFFE);
        chk("carry_lo", 64'(res_lo), 64'h1);
        run_op(32'h1234_5678, 32'd0, "b_zero");
        run_op(32'd0, 32'd7, "a_zero");

        // Start re-asserted with new operands mid-RUN: ignored, one Done only
        op_a = 32'h1111; op_b = 32'h2222; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; op_a = 32'hAAAA; op_b = 32'h5555;
        ndone = 0;
        for (int t = 4; t < W + 8; t++) begin
            if (t == 20) start = 1'b0;
            tick();
            if (done) begin
                ndone++;
                chk("midrun_product", {res_hi, res_lo}, 64'h1111 * 64'h2222);
            end
        end
        chk("midrun_one_done", 64'(ndone), 64'd1);
        chk("midrun_idle", 64'(busy), 64'd0);

        // Reset at iteration 10 aborts the operation
        op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_lo", 64'(res_lo), 64'd0);
        chk("abort_hi", 64'(res_hi), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        tick();
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op(32'd6, 32'd7, "restart");
        chk("restart_lo", 64'(res_lo), 64'd42);

        // Start held high: back-to-back every W+2 edges
        op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        tick();
        for (int t = 1; t <= 3 * (W + 2); t++) begin
            tick();
            if (done) begin
                tdone.push_back(t);
                chk("b2b_lo", 64'(res_lo), 64'd6);
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(tdone.size()), 64'd3);
        for (int k = 0; k < tdone.size(); k++)
            chk("b2b_spacing", 64'(tdone[k]), 64'(W + k * (W + 2)));
        n = 0; seen = 0;
        while (n < 2 * W && !seen) begin
            tick();
            n++;
            if (!busy) seen = 1;
        end
        chk("b2b_drain", 64'(seen), 64'd1);

        for (int i = 0; i < 10; i++) run_op($urandom, $urandom, "random");
        run_op(32'h8000_0000, 32'h8000_0001, "msb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
